// File: rtl/cia_arbiter_pkg.sv
// Shared definitions for the carry-chaining adder arbiter.
// State encodings, datapath word width, response-register layout
// and a small wraparound index helper used by the pointer update.
package cia_arbiter_pkg;

  localparam logic [0:0] CIA_IDLE = 1'b0;
  localparam logic [0:0] CIA_BUSY = 1'b1;
  localparam int         CIA_W    = 32;

  // Contents of the single-entry response register (id kept separately,
  // its width depends on the instance's requester count).
  typedef struct packed {
    logic [CIA_W-1:0] sum;
    logic             cout;
    logic             last;
  } rsp_t;

  // (idx + 1) mod n without a divider.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/Carryincadder.sv
// Purpose: 32-bit adder with carry-in and carry-out.
// Latency: combinational.
// Backpressure: none (pure datapath).
// Ports: a, b operands; cin carry-in; sum result word; cout carry-out.
module Carryincadder
  import cia_arbiter_pkg::*;
(
  input  logic [CIA_W-1:0] a,
  input  logic [CIA_W-1:0] b,
  input  logic             cin,
  output logic [CIA_W-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CIA_W{1'b0}}, cin};

endmodule

// File: rtl/rr_arb.sv
// Purpose: round-robin requester search starting at a pointer, with wraparound.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is taken.
// Ports: req request vector; ptr search start; gnt chosen index; any = some request set.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  gnt,
  output logic            any
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest hit after ptr wins.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      if (req[idx]) begin
        gnt = IDW'(idx);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cia_arbiter.sv
// Purpose: time-multiplexes one 32-bit carry-in adder among NREQ requesters, chaining carry per packet.
// Latency: grant 1 cycle after req_valid in IDLE; response registered 1 cycle after word accept.
// Backpressure: req_ready of the granted requester follows !rsp_valid | rsp_ready; rsp_* held while stalled.
// Ports: clk, rst_n; req_valid/req_ready/req_a/req_b/req_cin/req_last per requester (packed, requester i
//        at slice i); rsp_valid/rsp_ready handshake with rsp_sum, rsp_cout, rsp_id, rsp_last.
module cia_arbiter
  import cia_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WORDS_MAX = 4,
  parameter int IDW       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*CIA_W-1:0] req_a,
  input  logic [NREQ*CIA_W-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  input  logic [NREQ-1:0]       req_last,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [CIA_W-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_last
);

  localparam int BW = (WORDS_MAX > 1) ? $clog2(WORDS_MAX) : 1;

  logic [0:0]       state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   gnt_q;
  logic             carry_q;
  logic             first_q;
  logic [BW-1:0]    beat_q;
  rsp_t             rsp_q;
  logic [IDW-1:0]   rsp_id_q;
  logic             rsp_valid_q;

  logic [IDW-1:0]   arb_gnt;
  logic             arb_any;
  logic [CIA_W-1:0] op_a;
  logic [CIA_W-1:0] op_b;
  logic             add_cin;
  logic [CIA_W-1:0] add_sum;
  logic             add_cout;
  logic             out_free;
  logic             accept;
  logic             pkt_end;

  rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .any (arb_any)
  );

  // Operands come straight from the granted requester's slice; the only
  // register on this path is the response register.
  assign op_a    = req_a[int'(gnt_q)*CIA_W +: CIA_W];
  assign op_b    = req_b[int'(gnt_q)*CIA_W +: CIA_W];
  // First word of a packet takes the requester's carry-in; later words chain.
  assign add_cin = first_q ? req_cin[gnt_q] : carry_q;

  Carryincadder u_add (
    .a    (op_a),
    .b    (op_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Response slot can take a word if empty or being drained this edge.
  assign out_free = !rsp_valid_q || rsp_ready;
  assign accept   = (state_q == CIA_BUSY) && req_valid[gnt_q] && out_free;
  // Packet ends on last, or forcibly once WORDS_MAX words have been taken.
  assign pkt_end  = req_last[gnt_q] || (beat_q == BW'(WORDS_MAX - 1));

  always_comb begin
    req_ready = '0;
    if (state_q == CIA_BUSY) begin
      req_ready[gnt_q] = out_free;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CIA_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      carry_q     <= 1'b0;
      first_q     <= 1'b0;
      beat_q      <= '0;
      rsp_q       <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (state_q == CIA_IDLE) begin
        if (arb_any) begin
          gnt_q   <= arb_gnt;
          state_q <= CIA_BUSY;
          first_q <= 1'b1;
          beat_q  <= '0;
        end
      end else if (accept) begin
        carry_q <= add_cout;
        first_q <= 1'b0;
        beat_q  <= beat_q + 1'b1;
        if (pkt_end) begin
          state_q <= CIA_IDLE;
          ptr_q   <= IDW'(next_idx(int'(gnt_q), NREQ));
        end
      end

      // A fill overrides a drain on the same edge, so back-to-back words
      // flow without a bubble.
      if (accept) begin
        rsp_q       <= '{sum: add_sum, cout: add_cout, last: pkt_end};
        rsp_id_q    <= gnt_q;
        rsp_valid_q <= 1'b1;
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_q.sum;
  assign rsp_cout  = rsp_q.cout;
  assign rsp_last  = rsp_q.last;
  assign rsp_id    = rsp_id_q;

endmodule
